// File: rtl/rr_dff_arbiter.sv
// Round-robin arbiter sharing one DW-bit register among NREQ requesters.
// Optional grant cap of MAX_HOLD loads is enabled by defining ARB_TIMEOUT_EN.
module rr_dff_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    asyn_reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [DW-1:0]           q,
    output logic                    q_valid
);

    localparam int OW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || DW < 1 || MAX_HOLD < 1) begin : g_param_check
        $error("rr_dff_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [DW-1:0]     q_q, q_d;
    logic              q_valid_q, q_valid_d;

    logic              win_found;
    logic [OW-1:0]     win_idx;
    logic [OW-1:0]     cand;
    logic [DW-1:0]     owner_data;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0]     hold_q, hold_d;
    logic [HW-1:0]     hold_inc;

    assign hold_inc = hold_q + HW'(1);
`endif

    assign owner_data = wdata[int'(owner_q)*DW +: DW];

    // First requester at or after ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = OW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    ptr_d          = OW'((int'(win_idx) + 1) % NREQ);
                    state_d        = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d         = '0;
`endif
                end
            end
            GRANT: begin
                if (req[owner_q]) begin
                    q_d       = owner_data;
                    q_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d    = hold_inc;
                    // Cap reached: this load is the last one of the grant.
                    if (hold_inc == HW'(MAX_HOLD)) begin
                        gnt_d   = '0;
                        state_d = RELEASE;
                    end
`endif
                end else begin
                    gnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_rr_dff_arbiter.sv
// Directed bench for rr_dff_arbiter with a cycle-level reference model.
// Honours ARB_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_rr_dff_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;
    localparam int OW       = $clog2(NREQ);

    localparam int PH_IDLE  = 0;
    localparam int PH_OWNED = 1;
    localparam int PH_GAP   = 2;

    logic               clk = 1'b0;
    logic               asyn_reset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    gnt;
    logic [OW-1:0]      owner;
    logic [DW-1:0]      q;
    logic               q_valid;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_dff_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .req        (req),
        .wdata      (wdata),
        .gnt        (gnt),
        .owner      (owner),
        .q          (q),
        .q_valid    (q_valid)
    );

    // Reference model: who owns the register, how many loads so far, what it holds.
    int              m_phase = PH_IDLE;
    logic [NREQ-1:0] m_gnt   = '0;
    int              m_owner = 0;
    int              m_next  = 0;
    int              m_loads = 0;
    logic [DW-1:0]   m_q     = '0;
    logic            m_qv    = 1'b0;

    task automatic model_clear();
        m_phase = PH_IDLE;
        m_gnt   = '0;
        m_owner = 0;
        m_next  = 0;
        m_loads = 0;
        m_q     = '0;
        m_qv    = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        if (m_phase == PH_IDLE) begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(m_next + k) % NREQ]) w = (m_next + k) % NREQ;
            if (w >= 0) begin
                m_gnt        = '0;
                m_gnt[w]     = 1'b1;
                m_owner      = w;
                m_next       = (w + 1) % NREQ;
                m_loads      = 0;
                m_phase      = PH_OWNED;
            end
        end else if (m_phase == PH_OWNED) begin
            if (req[m_owner]) begin
                m_q     = wdata[m_owner*DW +: DW];
                m_qv    = 1'b1;
                m_loads = m_loads + 1;
`ifdef ARB_TIMEOUT_EN
                if (m_loads == MAX_HOLD) begin
                    m_gnt   = '0;
                    m_phase = PH_GAP;
                end
`endif
            end else begin
                m_gnt   = '0;
                m_phase = PH_GAP;
            end
        end else begin
            m_phase = PH_IDLE;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge asyn_reset);
        if (asyn_reset) model_clear();
        else            model_edge();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        vectors++;
        if (gnt !== m_gnt || owner !== OW'(m_owner) || q !== m_q || q_valid !== m_qv) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t gnt=%b exp=%b owner=%0d exp=%0d q=%h exp=%h q_valid=%b exp=%b",
                     $time, gnt, m_gnt, owner, m_owner, q, m_q, q_valid, m_qv);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic set_wd(input int i, input logic [DW-1:0] v);
        wdata[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        req = '0;
        @(negedge clk);
        #2 asyn_reset = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qv", 32'(q_valid), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        @(negedge clk);
        asyn_reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset, then a mid-cycle reset checked without a clock edge.
        @(negedge clk);
        chk("por_gnt", 32'(gnt), 32'h0);
        chk("por_qv", 32'(q_valid), 32'h0);
        asyn_reset = 1'b0;
        do_reset();

        // Single requester 2.
        set_wd(2, 8'hA5);
        req = 4'b0100;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_q_before", 32'(q), 32'h0);
        chk("t1_owner", 32'(owner), 32'h2);
        @(negedge clk);
        chk("t1_q", 32'(q), 32'hA5);
        chk("t1_qv", 32'(q_valid), 32'h1);
        req = '0;
        repeat (3) @(negedge clk);

        // All requesting; each owner drops after 2 loads then re-raises.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_wd(i, 8'h10 + 8'(i));
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("fair_gnt", 32'(gnt), 32'h1 << (g % NREQ));
            @(negedge clk);
            @(negedge clk);
            chk("fair_q", 32'(q), 32'h10 + 32'(g % NREQ));
            req[g % NREQ] = 1'b0;
            @(negedge clk);
            chk("fair_release", 32'(gnt), 32'h0);
            req = 4'b1111;
            @(negedge clk);
            chk("fair_idle", 32'(gnt), 32'h0);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Owner 1 streams data while requester 3 waits.
        do_reset();
        set_wd(1, 8'h01);
        set_wd(3, 8'h77);
        req = 4'b1010;
        @(negedge clk);
        chk("t3_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        chk("t3_q1", 32'(q), 32'h01);
        set_wd(1, 8'h02);
        @(negedge clk);
        chk("t3_q2", 32'(q), 32'h02);
        set_wd(1, 8'h03);
        @(negedge clk);
        chk("t3_q3", 32'(q), 32'h03);
        chk("t3_gnt_held", 32'(gnt), 32'h2);
        req = 4'b1000;
        @(negedge clk);
        chk("t3_rel", 32'(gnt), 32'h0);
        chk("t3_q_hold", 32'(q), 32'h03);
        @(negedge clk);
        chk("t3_idle", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("t3_gnt3", 32'(gnt), 32'h8);
        @(negedge clk);
        chk("t3_q3data", 32'(q), 32'h77);
        req = '0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a grant.
        do_reset();
        set_wd(2, 8'h5A);
        req = 4'b0100;
        @(negedge clk);
        chk("t4_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        chk("t4_q", 32'(q), 32'h5A);
        #2 asyn_reset = 1'b1;
        #1;
        chk("t4_rst_gnt", 32'(gnt), 32'h0);
        chk("t4_rst_q", 32'(q), 32'h0);
        chk("t4_rst_qv", 32'(q_valid), 32'h0);
        req = 4'b1111;
        @(negedge clk);
        asyn_reset = 1'b0;
        @(negedge clk);
        chk("t4_first", 32'(gnt), 32'h1);
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        // Requester 2 holds continuously with requester 0 also waiting.
        set_wd(2, 8'hC0);
        set_wd(0, 8'h3C);
        req = 4'b0101;
        @(negedge clk);
        chk("t5_gnt", 32'(gnt), 32'h4);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < MAX_HOLD; k++) begin
            @(negedge clk);
            chk("t5_q", 32'(q), 32'hC0 + 32'(k));
            set_wd(2, 8'hC1 + 8'(k));
        end
        chk("t5_cap_rel", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("t5_idle", 32'(gnt), 32'h0);
        @(negedge clk);
        chk("t5_gnt0", 32'(gnt), 32'h1);
        @(negedge clk);
        chk("t5_q0", 32'(q), 32'h3C);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t5_hold_gnt", 32'(gnt), 32'h4);
            chk("t5_hold_qv", 32'(q_valid), 32'h1);
            chk("t5_hold_q", 32'(q), 32'hC0 + 32'(k));
            set_wd(2, 8'hC1 + 8'(k));
        end
`endif
        req = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
